channel_vector_memory: RTL and testbench

- Responder side of the encoder's channel-vector fetch interface.
- Holds, per channel address, three hypervectors: item vector (iM), negative projection (projM_neg) and positive projection (projM_pos).
- Serves address requests from one spatial-encoder modality port with a valid/ready handshake.
- Programmed over a chunked load port; one instance per modality.

---
 rtl/channel_vector_memory_pkg.sv | 26 ++
 rtl/channel_vector_memory_resp_fifo.sv | 44 ++++
 rtl/channel_vector_memory.sv | 142 ++++++++++++++
 tb/tb_channel_vector_memory.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/channel_vector_memory_pkg.sv
// Shared constants, load-select encodings and FSM state type for the
// channel vector memory and its response FIFO.
package channel_vector_memory_pkg;

    localparam int DEF_HV_DIMENSION = 2048;
    localparam int INPUT_CHANNELS   = 214;
    localparam int DEF_LOAD_WIDTH   = 64;

    localparam logic [1:0] SEL_IM       = 2'd0;
    localparam logic [1:0] SEL_PROJ_NEG = 2'd1;
    localparam logic [1:0] SEL_PROJ_POS = 2'd2;
    localparam logic [1:0] SEL_ILLEGAL  = 2'd3;

    typedef enum logic {
        SERVE = 1'b0,
        LOAD  = 1'b1
    } state_t;

    function automatic int ceilLog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/channel_vector_memory_resp_fifo.sv
// Two-entry valid/ready FIFO carrying {err, iM, projNeg, projPos} responses.
// Output data reads as zero whenever the FIFO is empty.
module hv_resp_fifo #(
    parameter int WIDTH = 3 * 2048 + 1
) (
    input  logic             Clk_CI,
    input  logic             Reset_RI,
    input  logic             InValid_SI,
    output logic             InReady_SO,
    input  logic [WIDTH-1:0] InData_DI,
    output logic             OutValid_SO,
    input  logic             OutReady_SI,
    output logic [WIDTH-1:0] OutData_DO
);

    logic [WIDTH-1:0] slotQ [2];
    logic             wrPtrQ, rdPtrQ;
    logic [1:0]       cntQ;
    logic             push, pop;

    assign InReady_SO  = (cntQ != 2'd2);
    assign OutValid_SO = (cntQ != 2'd0);
    assign OutData_DO  = OutValid_SO ? slotQ[rdPtrQ] : '0;
    assign push        = InValid_SI && InReady_SO;
    assign pop         = OutValid_SO && OutReady_SI;

    // Ring of two slots; push and pop may happen on the same edge.
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RI) begin
            for (int i = 0; i < 2; i++) slotQ[i] <= '0;
            wrPtrQ <= 1'b0;
            rdPtrQ <= 1'b0;
            cntQ   <= 2'd0;
        end else begin
            if (push) begin
                slotQ[wrPtrQ] <= InData_DI;
                wrPtrQ        <= ~wrPtrQ;
            end
            if (pop) rdPtrQ <= ~rdPtrQ;
            cntQ <= cntQ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/channel_vector_memory.sv
// Per-modality channel vector store: serves iM/projNeg/projPos reads for the
// spatial encoder and is programmed in LOAD_WIDTH chunks between reads.
module channel_vector_memory
    import channel_vector_memory_pkg::*;
#(
    parameter int HV_DIMENSION = DEF_HV_DIMENSION,
    parameter int DEPTH        = INPUT_CHANNELS,
    parameter int ADDR_WIDTH   = ceilLog2(DEPTH),
    parameter int LOAD_WIDTH   = DEF_LOAD_WIDTH
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ReqValid_SI,
    output logic                    ReqReady_SO,
    input  logic [ADDR_WIDTH-1:0]   ReqAddr_DI,
    output logic                    RspValid_SO,
    input  logic                    RspReady_SI,
    output logic [0:HV_DIMENSION-1] IMOut_DO,
    output logic [0:HV_DIMENSION-1] ProjNegOut_DO,
    output logic [0:HV_DIMENSION-1] ProjPosOut_DO,
    output logic                    RspErr_SO,
    input  logic                    LoadValid_SI,
    output logic                    LoadReady_SO,
    input  logic [ADDR_WIDTH-1:0]   LoadAddr_DI,
    input  logic [1:0]              LoadSel_DI,
    input  logic [LOAD_WIDTH-1:0]   LoadData_DI,
    output logic                    LoadDone_SO
);

    localparam int NUM_CHUNKS = HV_DIMENSION / LOAD_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? ceilLog2(NUM_CHUNKS) : 1;
    localparam int IDX_W      = (DEPTH > 1) ? ceilLog2(DEPTH) : 1;
    localparam int RSP_W      = 3 * HV_DIMENSION + 1;

    // Storage, indexed by load select (iM, projNeg, projPos).
    logic [0:HV_DIMENSION-1] memQ [3][DEPTH];

    state_t                  state;
    logic [CNT_W-1:0]        chunkCnt;
    logic [ADDR_WIDTH-1:0]   loadAddrQ, commitAddr;
    logic [1:0]              loadSelQ, commitSel;
    logic [0:HV_DIMENSION-1] asmQ, asmD;
    logic [1:0]              credits;
    logic                    loadDoneQ;
    logic                    reqFire, rspPop, loadFire, lastChunk, commitOk;
    logic                    rdInRange, fifoInReady;
    logic [IDX_W-1:0]        rdIdx, commitIdx;
    logic [RSP_W-1:0]        rspIn, rspOut;

    // Handshakes; readies are forced low while reset is asserted.
    assign ReqReady_SO  = Reset_RI && (state == SERVE) && !LoadValid_SI &&
                          (credits < 2'd2) && fifoInReady;
    assign LoadReady_SO = Reset_RI && (state == LOAD);
    assign reqFire      = ReqValid_SI && ReqReady_SO;
    assign rspPop       = RspValid_SO && RspReady_SI;
    assign loadFire     = LoadValid_SI && LoadReady_SO;
    assign lastChunk    = loadFire && (chunkCnt == CNT_W'(NUM_CHUNKS - 1));
    assign LoadDone_SO  = loadDoneQ;

    // Read path: out-of-range addresses return zero vectors flagged with err.
    assign rdInRange = 32'(ReqAddr_DI) < DEPTH;
    assign rdIdx     = ReqAddr_DI[IDX_W-1:0];
    assign rspIn     = rdInRange ?
                       {1'b0, memQ[SEL_IM][rdIdx], memQ[SEL_PROJ_NEG][rdIdx], memQ[SEL_PROJ_POS][rdIdx]} :
                       {1'b1, {(RSP_W-1){1'b0}}};

    hv_resp_fifo #(.WIDTH(RSP_W)) i_rspFifo (
        .Clk_CI      (Clk_CI),
        .Reset_RI    (Reset_RI),
        .InValid_SI  (reqFire),
        .InReady_SO  (fifoInReady),
        .InData_DI   (rspIn),
        .OutValid_SO (RspValid_SO),
        .OutReady_SI (RspReady_SI),
        .OutData_DO  (rspOut)
    );

    assign RspErr_SO     = rspOut[RSP_W-1];
    assign IMOut_DO      = rspOut[3*HV_DIMENSION-1 -: HV_DIMENSION];
    assign ProjNegOut_DO = rspOut[2*HV_DIMENSION-1 -: HV_DIMENSION];
    assign ProjPosOut_DO = rspOut[HV_DIMENSION-1 -: HV_DIMENSION];

    // Target address/select come straight from the port on chunk 0 so a
    // single-chunk vector commits correctly; later chunks use the held copy.
    assign commitAddr = (chunkCnt == '0) ? LoadAddr_DI : loadAddrQ;
    assign commitSel  = (chunkCnt == '0) ? LoadSel_DI  : loadSelQ;
    assign commitIdx  = commitAddr[IDX_W-1:0];
    assign commitOk   = (32'(commitAddr) < DEPTH) && (commitSel != SEL_ILLEGAL);

    // Assembly view with the current chunk merged in, so the last chunk
    // commits in the same edge it is accepted.
    always_comb begin
        asmD = asmQ;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (chunkCnt == CNT_W'(k)) asmD[k*LOAD_WIDTH +: LOAD_WIDTH] = LoadData_DI;
        end
    end

    // Assembly register; a partial vector is abandoned when the counter resets.
    always_ff @(posedge Clk_CI) begin
        if (loadFire) asmQ <= asmD;
    end

    // Whole-vector commit, so readers never observe a half-written entry.
    always_ff @(posedge Clk_CI) begin
        if (lastChunk && commitOk) memQ[commitSel][commitIdx] <= asmD;
    end

    // SERVE/LOAD control, response credits and the load-done pulse.
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RI) begin
            state     <= SERVE;
            chunkCnt  <= '0;
            credits   <= 2'd0;
            loadDoneQ <= 1'b0;
            loadAddrQ <= '0;
            loadSelQ  <= SEL_IM;
        end else begin
            loadDoneQ <= lastChunk;
            credits   <= credits + {1'b0, reqFire} - {1'b0, rspPop};
            case (state)
                SERVE: if (LoadValid_SI && credits == 2'd0) state <= LOAD;
                LOAD: begin
                    if (loadFire) begin
                        if (chunkCnt == '0) begin
                            loadAddrQ <= LoadAddr_DI;
                            loadSelQ  <= LoadSel_DI;
                        end
                        if (lastChunk) begin
                            chunkCnt <= '0;
                            state    <= SERVE;
                        end else begin
                            chunkCnt <= chunkCnt + 1'b1;
                        end
                    end
                end
                default: state <= SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_vector_memory.sv
// Directed bench for channel_vector_memory at HV=128, LOAD_WIDTH=32, DEPTH=8.
module tb_channel_vector_memory;

    localparam int HV    = 128;
    localparam int LW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          reqValid = 1'b0, reqReady, rspValid, rspReady = 1'b0, rspErr;
    logic          loadValid = 1'b0, loadReady, loadDone;
    logic [AW-1:0] reqAddr = '0, loadAddr = '0;
    logic [1:0]    loadSel = '0;
    logic [LW-1:0] loadData = '0;
    logic [0:HV-1] imOut, negOut, posOut;

    logic [HV-1:0] expM [3][DEPTH];
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    channel_vector_memory #(
        .HV_DIMENSION (HV),
        .DEPTH        (DEPTH),
        .ADDR_WIDTH   (AW),
        .LOAD_WIDTH   (LW)
    ) dut (
        .Clk_CI        (clk),
        .Reset_RI      (rstN),
        .ReqValid_SI   (reqValid),
        .ReqReady_SO   (reqReady),
        .ReqAddr_DI    (reqAddr),
        .RspValid_SO   (rspValid),
        .RspReady_SI   (rspReady),
        .IMOut_DO      (imOut),
        .ProjNegOut_DO (negOut),
        .ProjPosOut_DO (posOut),
        .RspErr_SO     (rspErr),
        .LoadValid_SI  (loadValid),
        .LoadReady_SO  (loadReady),
        .LoadAddr_DI   (loadAddr),
        .LoadSel_DI    (loadSel),
        .LoadData_DI   (loadData),
        .LoadDone_SO   (loadDone)
    );

    task automatic chk(input string tag, input logic [HV-1:0] got, input logic [HV-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [HV-1:0] pat(input int a, input int s);
        logic [HV-1:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[HV-1-LW*k -: LW] = {8'(a), 8'(s), 8'(k), 8'hC3};
        return v;
    endfunction

    task automatic chk_rsp(input string tag, input int a);
        chk({tag, "_vld"}, rspValid, 1);
        chk({tag, "_err"}, rspErr, 0);
        chk({tag, "_im"},  imOut,  expM[0][a]);
        chk({tag, "_neg"}, negOut, expM[1][a]);
        chk({tag, "_pos"}, posOut, expM[2][a]);
    endtask

    task automatic send_chunk(input int a, input int s, input logic [LW-1:0] d);
        int n;
        n = 0;
        loadValid = 1'b1;
        loadAddr  = AW'(a);
        loadSel   = 2'(s);
        loadData  = d;
        #1;
        while (!loadReady && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("load_timeout", 0, 1);
        tick();
    endtask

    // Later chunks carry junk addr/sel, which the DUT must ignore.
    task automatic load_vec(input int a, input int s, input logic [HV-1:0] v, input bit gap);
        for (int k = 0; k < 4; k++) begin
            if (gap && k == 2) begin
                loadValid = 1'b0;
                tick();
                tick();
            end
            send_chunk((k == 0) ? a : 15 - a, (k == 0) ? s : 3 - s, v[HV-1-LW*k -: LW]);
        end
        chk("load_done", loadDone, 1);
        loadValid = 1'b0;
        tick();
        chk("load_done_clr", loadDone, 0);
        if (s < 3) expM[s][a] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 3; s++)
            for (int a = 0; a < DEPTH; a++) expM[s][a] = '0;

        // Reset held with toggling inputs.
        rstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            reqValid  = (i % 2 == 0);
            loadValid = (i % 2 == 1);
            rspReady  = (i % 2 == 0);
            reqAddr   = AW'(i + 1);
            loadData  = $urandom;
            tick();
            chk("rst_rspvld",  rspValid,  0);
            chk("rst_reqrdy",  reqReady,  0);
            chk("rst_loadrdy", loadReady, 0);
            chk("rst_done",    loadDone,  0);
        end
        reqValid = 1'b0; loadValid = 1'b0; rspReady = 1'b0;
        rstN = 1'b1;
        tick();
        chk("rel_reqrdy", reqReady, 1);
        chk("rel_rspvld", rspValid, 0);

        // Single load with a gap, then read it back.
        load_vec(3, 0, 128'hDEADBEEF0123456789ABCDEFCAFEF00D, 1'b1);
        rspReady = 1'b1;
        reqValid = 1'b1; reqAddr = 4'd3;
        #1;
        chk("t2_reqrdy", reqReady, 1);
        tick();
        reqValid = 1'b0;
        chk("t2_vld", rspValid, 1);
        chk("t2_im",  imOut, 128'hDEADBEEF0123456789ABCDEFCAFEF00D);
        chk("t2_err", rspErr, 0);
        tick();
        chk("t2_pop", rspValid, 0);

        // Fill every entry, then stream back-to-back reads.
        for (int a = 0; a < DEPTH; a++)
            for (int s = 0; s < 3; s++) load_vec(a, s, pat(a, s), 1'b0);
        rspReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reqValid = 1'b1; reqAddr = AW'(i);
            #1;
            chk("b2b_rdy", reqReady, 1);
            if (i > 0) chk_rsp("b2b", i - 1);
            tick();
        end
        reqValid = 1'b0;
        #1;
        chk_rsp("b2b_last", 7);
        tick();
        chk("b2b_empty", rspValid, 0);

        // Backpressure: only two accepted, head held stable, order kept.
        rspReady = 1'b0;
        reqValid = 1'b1; reqAddr = 4'd1;
        #1; chk("bp_rdy0", reqReady, 1); tick();
        reqAddr = 4'd2;
        #1; chk("bp_rdy1", reqReady, 1); tick();
        reqAddr = 4'd5;
        #1; chk("bp_rdy_drop", reqReady, 0); chk_rsp("bp_hold0", 1); tick();
        chk("bp_rdy_low", reqReady, 0); chk_rsp("bp_hold1", 1); tick();
        chk_rsp("bp_hold2", 1);
        rspReady = 1'b1;
        #1; chk_rsp("bp_a1", 1); chk("bp_rdy_full", reqReady, 0); tick();
        chk("bp_rdy_back", reqReady, 1); chk_rsp("bp_a2", 2); tick();
        reqValid = 1'b0;
        #1; chk_rsp("bp_a5", 5); tick();
        chk("bp_empty", rspValid, 0);

        // Out-of-range address, followed by a normal read.
        reqValid = 1'b1; reqAddr = 4'd9;
        #1; chk("oor_rdy", reqReady, 1); tick();
        reqAddr = 4'd2;
        #1;
        chk("oor_vld", rspValid, 1);
        chk("oor_err", rspErr, 1);
        chk("oor_im",  imOut, 0);
        chk("oor_neg", negOut, 0);
        chk("oor_pos", posOut, 0);
        chk("oor_rdy2", reqReady, 1);
        tick();
        reqValid = 1'b0;
        #1; chk_rsp("oor_next", 2); tick();

        // Pending load waits for the response path to drain; reset mid-load.
        rspReady = 1'b0;
        reqValid = 1'b1; reqAddr = 4'd4; tick();
        reqAddr = 4'd6; tick();
        reqValid = 1'b0;
        loadValid = 1'b1; loadAddr = 4'd4; loadSel = 2'd0; loadData = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld_blk_loadrdy", loadReady, 0);
            chk("ld_blk_reqrdy",  reqReady,  0);
            chk("ld_blk_rspvld",  rspValid,  1);
            tick();
        end
        rspReady = 1'b1;
        #1; chk_rsp("drain0", 4); tick();
        chk_rsp("drain1", 6); chk("drain_loadrdy", loadReady, 0); tick();
        send_chunk(4, 0, 32'h11111111);
        send_chunk(4, 0, 32'h22222222);
        send_chunk(4, 0, 32'h33333333);
        loadValid = 1'b0;
        rstN = 1'b0;
        tick();
        chk("mid_rst_done",    loadDone,  0);
        chk("mid_rst_loadrdy", loadReady, 0);
        rstN = 1'b1;
        tick();
        chk("mid_rst_reqrdy", reqReady, 1);
        reqValid = 1'b1; reqAddr = 4'd4; tick();
        reqValid = 1'b0;
        #1; chk_rsp("rst_keep", 4); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
